endec_axis_tx: RTL and testbench
================================

ENDEC_AXIS_TX -- requirements
Module: endec_axis_tx

Interface
REQ-001 SHALL have parameter TDATA_W, default 32, AXI-Stream data width; only 32 is supported.
REQ-002 SHALL have port sys_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_frame_data  input  384  encoder output frame; bit 0 is first coded bit.
REQ-005 SHALL have port i_code_rate  input  1  0 = rate 1/2 (256 valid bits, 8 words); 1 = rate 1/3 (384 bits, 12 words).
REQ-006 SHALL have port i_constr_len  input  1  constraint-length select; carried into the header only.
REQ-007 SHALL have port i_frame_valid  input  1  frame offered; driven from o_encoder_done.
REQ-008 SHALL have port o_frame_ready  output  1  block can capture a frame this cycle.
REQ-009 SHALL have port axi_tx_tdata  output  32  stream data.
REQ-010 SHALL have port axi_tx_tvalid  output  1  stream valid.
REQ-011 SHALL have port axi_tx_tlast  output  1  last beat of frame.
REQ-012 SHALL have port axi_tx_tready  input  1  downstream ready.
REQ-013 SHALL have port o_frame_sent  output  1  one-cycle pulse after the last beat handshakes.

Function
REQ-014 SHALL implement FSM with states IDLE, SEND; o_frame_ready = 1 only in IDLE.
REQ-015 SHALL capture i_frame_data, i_code_rate, i_constr_len on the edge where i_frame_valid && o_frame_ready, and enter SEND; i_frame_valid in SEND is ignored (no capture, no queueing).
REQ-016 SHALL assert axi_tx_tvalid on the first cycle after capture (one-cycle latency) and hold it until the last beat handshakes.
REQ-017 SHALL send beat n as captured bits [32n+31:32n], n = 0 upward; beat count N = 8 (rate 1/2) or 12 (rate 1/3).
REQ-018 SHALL advance the beat counter only on axi_tx_tvalid && axi_tx_tready; tdata and tlast stable while tvalid && !tready.
REQ-019 SHALL assert axi_tx_tlast only on beat N-1.
REQ-020 SHALL, on the last-beat handshake, deassert tvalid next cycle, return to IDLE, pulse o_frame_sent for that one cycle; o_frame_ready high in that same cycle (minimum gap between frames: one cycle).
REQ-021 SHALL never depend on i_frame_data after capture; input may change freely during SEND.
REQ-022 SHALL keep tvalid low and tdata = 0 in IDLE.

Reset
REQ-023 SHALL, with rst = 1 at an edge, force IDLE, beat counter 0, capture register 0, axi_tx_tvalid 0, axi_tx_tlast 0, axi_tx_tdata 0, o_frame_sent 0, o_frame_ready 1 from the next cycle.
REQ-024 SHALL, on reset mid-frame, drop the frame with no tlast and no o_frame_sent; rst takes priority over a simultaneous i_frame_valid.

Configuration
REQ-025 SHALL, when macro ENDEC_AXIS_TX_HDR_EN is defined, send one header beat before payload: [31:28] = 4'hA, [27:16] = 0, [15:8] = N, [7:2] = 0, [1] = constr_len, [0] = code_rate; frame becomes N+1 beats, tlast on beat N (last payload beat).
REQ-026 SHALL, without ENDEC_AXIS_TX_HDR_EN, send payload only (N beats) with no header logic present.

Verification
REQ-027 SHALL test rate 1/2, tready held 1, frame bits [31:0] = 32'h0000_0011 -> 8 consecutive beats, first tdata 32'h0000_0011, tlast on beat 8, o_frame_sent one cycle later, tvalid first high one cycle after capture.
REQ-028 SHALL test rate 1/3 with tready toggling 1/0 every cycle -> 12 handshakes, tdata/tlast unchanged across every stall, tlast only on 12th.
REQ-029 SHALL test i_frame_valid held high with new data during SEND -> second frame captured only in IDLE cycle after o_frame_sent; first frame data uncorrupted.
REQ-030 SHALL test rst pulsed after beat 4 of 12 -> tvalid 0 next cycle, no tlast, no o_frame_sent, o_frame_ready 1; subsequent frame sent from beat 0.
REQ-031 SHALL test (ENDEC_AXIS_TX_HDR_EN defined) rate 1/3, constr_len 1 -> first beat 32'hA000_0C03, then 12 payload beats, tlast on 13th beat.

Source files
------------

// File: rtl/endec_axis_tx.sv
// Serialises one captured 384-bit encoder frame into 8 or 12 AXI-Stream beats.
// Define ENDEC_AXIS_TX_HDR_EN to prepend a header beat carrying beat count and code parameters.
module endec_axis_tx #(
  parameter int TDATA_W = 32
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [383:0]       i_frame_data,
  input  logic               i_code_rate,
  input  logic               i_constr_len,
  input  logic               i_frame_valid,
  output logic               o_frame_ready,
  output logic [TDATA_W-1:0] axi_tx_tdata,
  output logic               axi_tx_tvalid,
  output logic               axi_tx_tlast,
  input  logic               axi_tx_tready,
  output logic               o_frame_sent
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t       state_q, state_d;
  logic [383:0] frame_q, frame_d;
  logic         rate_q, rate_d;
  logic [3:0]   beat_q, beat_d;
  logic         sent_q, sent_d;
  logic [3:0]   last_beat;
  logic [3:0]   word_idx;
  logic [8:0]   bit_off;
  logic         hs;

`ifdef ENDEC_AXIS_TX_HDR_EN
  logic         cl_q, cl_d;
  logic [7:0]   payload_n;
`else
  logic         unused_constr_len;
  assign unused_constr_len = i_constr_len;
`endif

  assign hs            = axi_tx_tvalid && axi_tx_tready;
  assign o_frame_ready = (state_q == IDLE);
  assign axi_tx_tvalid = (state_q == SEND);
  assign axi_tx_tlast  = (state_q == SEND) && (beat_q == last_beat);
  assign o_frame_sent  = sent_q;

  // Beat 0 is the header when enabled, so payload words lag the beat counter by one.
  always_comb begin
`ifdef ENDEC_AXIS_TX_HDR_EN
    payload_n = rate_q ? 8'd12 : 8'd8;
    last_beat = rate_q ? 4'd12 : 4'd8;
    word_idx  = (beat_q == 4'd0) ? 4'd0 : beat_q - 4'd1;
`else
    last_beat = rate_q ? 4'd11 : 4'd7;
    word_idx  = beat_q;
`endif
    bit_off = {word_idx, 5'b0};
  end

  always_comb begin
    axi_tx_tdata = '0;
    if (state_q == SEND) begin
      axi_tx_tdata = frame_q[bit_off +: TDATA_W];
`ifdef ENDEC_AXIS_TX_HDR_EN
      if (beat_q == 4'd0) begin
        axi_tx_tdata = {4'hA, 12'h000, payload_n, 6'b0, cl_q, rate_q};
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    rate_d  = rate_q;
    beat_d  = beat_q;
    sent_d  = 1'b0;
`ifdef ENDEC_AXIS_TX_HDR_EN
    cl_d    = cl_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_frame_valid) begin
          frame_d = i_frame_data;
          rate_d  = i_code_rate;
`ifdef ENDEC_AXIS_TX_HDR_EN
          cl_d    = i_constr_len;
`endif
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (beat_q == last_beat) begin
            beat_d  = '0;
            sent_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      rate_q  <= 1'b0;
      beat_q  <= '0;
      sent_q  <= 1'b0;
`ifdef ENDEC_AXIS_TX_HDR_EN
      cl_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      rate_q  <= rate_d;
      beat_q  <= beat_d;
      sent_q  <= sent_d;
`ifdef ENDEC_AXIS_TX_HDR_EN
      cl_q    <= cl_d;
`endif
    end
  end

endmodule

// File: tb/tb_endec_axis_tx.sv
// Directed self-checking bench for endec_axis_tx; follows ENDEC_AXIS_TX_HDR_EN if defined.
module tb_endec_axis_tx;

`ifdef ENDEC_AXIS_TX_HDR_EN
  localparam int HDR_BEATS = 1;
`else
  localparam int HDR_BEATS = 0;
`endif

  logic         sys_clk;
  logic         rst;
  logic [383:0] i_frame_data;
  logic         i_code_rate;
  logic         i_constr_len;
  logic         i_frame_valid;
  logic         o_frame_ready;
  logic [31:0]  axi_tx_tdata;
  logic         axi_tx_tvalid;
  logic         axi_tx_tlast;
  logic         axi_tx_tready;
  logic         o_frame_sent;

  int n_checks = 0;
  int n_fail   = 0;

  endec_axis_tx #(.TDATA_W(32)) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .i_frame_data  (i_frame_data),
    .i_code_rate   (i_code_rate),
    .i_constr_len  (i_constr_len),
    .i_frame_valid (i_frame_valid),
    .o_frame_ready (o_frame_ready),
    .axi_tx_tdata  (axi_tx_tdata),
    .axi_tx_tvalid (axi_tx_tvalid),
    .axi_tx_tlast  (axi_tx_tlast),
    .axi_tx_tready (axi_tx_tready),
    .o_frame_sent  (o_frame_sent)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [383:0] make_frame(input logic [31:0] seed);
    logic [383:0] f;
    for (int i = 0; i < 12; i++) f[i*32 +: 32] = seed ^ (i * 32'h0101_0101);
    return f;
  endfunction

  function automatic int nbeats(input logic r);
    return (r ? 12 : 8) + HDR_BEATS;
  endfunction

  function automatic logic [31:0] exp_beat(input logic [383:0] f, input logic r,
                                           input logic c, input int k);
    if (HDR_BEATS == 1 && k == 0) return {4'hA, 12'h000, (r ? 8'd12 : 8'd8), 6'b0, c, r};
    return f[(k - HDR_BEATS)*32 +: 32];
  endfunction

  task automatic test_reset;
    rst = 1'b1; i_frame_valid = 1'b0; i_frame_data = '0;
    i_code_rate = 1'b0; i_constr_len = 1'b0; axi_tx_tready = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++; if (axi_tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", axi_tx_tvalid); end
    n_checks++; if (axi_tx_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata got %h exp 0", axi_tx_tdata); end
    n_checks++; if (axi_tx_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b exp 0", axi_tx_tlast); end
    n_checks++; if (o_frame_sent !== 1'b0) begin n_fail++; $display("FAIL reset_sent got %b exp 0", o_frame_sent); end
    n_checks++; if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", o_frame_ready); end
    rst = 1'b0;
    @(negedge sys_clk);
    n_checks++; if (o_frame_ready !== 1'b1 || axi_tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle ready=%b tvalid=%b exp 1/0", o_frame_ready, axi_tx_tvalid); end
  endtask

  task automatic test_rate_half;
    logic [383:0] f;
    int nb;
    f = make_frame(32'h0000_0011);
    nb = nbeats(1'b0);
    i_frame_data = f; i_code_rate = 1'b0; i_constr_len = 1'b0;
    i_frame_valid = 1'b1; axi_tx_tready = 1'b1;
    n_checks++; if (axi_tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL half_tvalid_precap got %b exp 0", axi_tx_tvalid); end
    for (int k = 0; k < nb; k++) begin
      @(negedge sys_clk);
      i_frame_valid = 1'b0;
      i_frame_data = ~f;
      n_checks++; if (axi_tx_tvalid !== 1'b1) begin n_fail++; $display("FAIL half_tvalid k=%0d got %b exp 1", k, axi_tx_tvalid); end
      n_checks++; if (axi_tx_tdata !== exp_beat(f, 1'b0, 1'b0, k)) begin n_fail++; $display("FAIL half_tdata k=%0d got %h exp %h", k, axi_tx_tdata, exp_beat(f, 1'b0, 1'b0, k)); end
      n_checks++; if (axi_tx_tlast !== (k == nb-1)) begin n_fail++; $display("FAIL half_tlast k=%0d got %b exp %b", k, axi_tx_tlast, (k == nb-1)); end
      n_checks++; if (o_frame_ready !== 1'b0 || o_frame_sent !== 1'b0) begin n_fail++; $display("FAIL half_busy k=%0d ready=%b sent=%b exp 0/0", k, o_frame_ready, o_frame_sent); end
      if (k == HDR_BEATS) begin
        n_checks++; if (axi_tx_tdata !== 32'h0000_0011) begin n_fail++; $display("FAIL half_first_payload got %h exp 00000011", axi_tx_tdata); end
      end
    end
    @(negedge sys_clk);
    n_checks++; if (o_frame_sent !== 1'b1) begin n_fail++; $display("FAIL half_sent got %b exp 1", o_frame_sent); end
    n_checks++; if (axi_tx_tvalid !== 1'b0 || axi_tx_tdata !== 32'h0) begin n_fail++; $display("FAIL half_idle tvalid=%b tdata=%h exp 0/0", axi_tx_tvalid, axi_tx_tdata); end
    n_checks++; if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL half_ready_after got %b exp 1", o_frame_ready); end
    @(negedge sys_clk);
    n_checks++; if (o_frame_sent !== 1'b0) begin n_fail++; $display("FAIL half_sent_pulse got %b exp 0", o_frame_sent); end
  endtask

  task automatic test_rate_third_stall;
    logic [383:0] f;
    int nb, cnt, cycles;
    logic ph;
    f = make_frame(32'hA5C3_0F10);
    nb = nbeats(1'b1);
    i_frame_data = f; i_code_rate = 1'b1; i_constr_len = 1'b0;
    i_frame_valid = 1'b1; axi_tx_tready = 1'b0;
    cnt = 0; cycles = 0; ph = 1'b1;
    while (cnt < nb && cycles < 200) begin
      @(negedge sys_clk);
      i_frame_valid = 1'b0;
      axi_tx_tready = ph;
      n_checks++; if (axi_tx_tvalid !== 1'b1) begin n_fail++; $display("FAIL third_tvalid n=%0d got %b exp 1", cnt, axi_tx_tvalid); end
      n_checks++; if (axi_tx_tdata !== exp_beat(f, 1'b1, 1'b0, cnt)) begin n_fail++; $display("FAIL third_tdata n=%0d got %h exp %h", cnt, axi_tx_tdata, exp_beat(f, 1'b1, 1'b0, cnt)); end
      n_checks++; if (axi_tx_tlast !== (cnt == nb-1)) begin n_fail++; $display("FAIL third_tlast n=%0d got %b exp %b", cnt, axi_tx_tlast, (cnt == nb-1)); end
      n_checks++; if (o_frame_sent !== 1'b0) begin n_fail++; $display("FAIL third_sent_early n=%0d got %b exp 0", cnt, o_frame_sent); end
      if (ph) cnt++;
      ph = ~ph;
      cycles++;
    end
    n_checks++; if (cnt != nb) begin n_fail++; $display("FAIL third_timeout handshakes %0d exp %0d", cnt, nb); end
    @(negedge sys_clk);
    axi_tx_tready = 1'b1;
    n_checks++; if (o_frame_sent !== 1'b1 || axi_tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL third_end sent=%b tvalid=%b exp 1/0", o_frame_sent, axi_tx_tvalid); end
    @(negedge sys_clk);
  endtask

  task automatic test_back_to_back;
    logic [383:0] fa, fb;
    int na, nb;
    fa = make_frame(32'h1234_5678);
    fb = make_frame(32'h0BAD_F00D);
    na = nbeats(1'b0);
    nb = nbeats(1'b1);
    i_frame_data = fa; i_code_rate = 1'b0; i_constr_len = 1'b0;
    i_frame_valid = 1'b1; axi_tx_tready = 1'b1;
    for (int k = 0; k < na; k++) begin
      @(negedge sys_clk);
      i_frame_data = fb; i_code_rate = 1'b1; i_constr_len = 1'b1;
      n_checks++; if (axi_tx_tdata !== exp_beat(fa, 1'b0, 1'b0, k)) begin n_fail++; $display("FAIL b2b_a_tdata k=%0d got %h exp %h", k, axi_tx_tdata, exp_beat(fa, 1'b0, 1'b0, k)); end
      n_checks++; if (axi_tx_tlast !== (k == na-1)) begin n_fail++; $display("FAIL b2b_a_tlast k=%0d got %b exp %b", k, axi_tx_tlast, (k == na-1)); end
      n_checks++; if (o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_a_ready k=%0d got %b exp 0", k, o_frame_ready); end
    end
    @(negedge sys_clk);
    n_checks++; if (o_frame_sent !== 1'b1 || o_frame_ready !== 1'b1 || axi_tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap sent=%b ready=%b tvalid=%b exp 1/1/0", o_frame_sent, o_frame_ready, axi_tx_tvalid); end
    for (int k = 0; k < nb; k++) begin
      @(negedge sys_clk);
      i_frame_valid = 1'b0;
      n_checks++; if (axi_tx_tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_b_tvalid k=%0d got %b exp 1", k, axi_tx_tvalid); end
      n_checks++; if (axi_tx_tdata !== exp_beat(fb, 1'b1, 1'b1, k)) begin n_fail++; $display("FAIL b2b_b_tdata k=%0d got %h exp %h", k, axi_tx_tdata, exp_beat(fb, 1'b1, 1'b1, k)); end
      n_checks++; if (axi_tx_tlast !== (k == nb-1)) begin n_fail++; $display("FAIL b2b_b_tlast k=%0d got %b exp %b", k, axi_tx_tlast, (k == nb-1)); end
    end
    @(negedge sys_clk);
    n_checks++; if (o_frame_sent !== 1'b1) begin n_fail++; $display("FAIL b2b_b_sent got %b exp 1", o_frame_sent); end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid;
    logic [383:0] f, g;
    int nb;
    f = make_frame(32'h5500_00AA);
    g = make_frame(32'h0000_0077);
    i_frame_data = f; i_code_rate = 1'b1; i_constr_len = 1'b0;
    i_frame_valid = 1'b1; axi_tx_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      i_frame_valid = 1'b0;
      n_checks++; if (axi_tx_tdata !== exp_beat(f, 1'b1, 1'b0, k)) begin n_fail++; $display("FAIL rstmid_tdata k=%0d got %h exp %h", k, axi_tx_tdata, exp_beat(f, 1'b1, 1'b0, k)); end
    end
    @(negedge sys_clk);
    rst = 1'b1; i_frame_valid = 1'b1; i_frame_data = g;
    @(negedge sys_clk);
    rst = 1'b0; i_frame_valid = 1'b0;
    n_checks++; if (axi_tx_tvalid !== 1'b0 || axi_tx_tdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_tvalid tvalid=%b tdata=%h exp 0/0", axi_tx_tvalid, axi_tx_tdata); end
    n_checks++; if (axi_tx_tlast !== 1'b0 || o_frame_sent !== 1'b0) begin n_fail++; $display("FAIL rstmid_tlast_sent tlast=%b sent=%b exp 0/0", axi_tx_tlast, o_frame_sent); end
    n_checks++; if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", o_frame_ready); end
    repeat (2) begin
      @(negedge sys_clk);
      n_checks++; if (o_frame_sent !== 1'b0 || axi_tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet sent=%b tvalid=%b exp 0/0", o_frame_sent, axi_tx_tvalid); end
    end
    nb = nbeats(1'b0);
    i_frame_data = g; i_code_rate = 1'b0; i_frame_valid = 1'b1;
    for (int k = 0; k < nb; k++) begin
      @(negedge sys_clk);
      i_frame_valid = 1'b0;
      n_checks++; if (axi_tx_tdata !== exp_beat(g, 1'b0, 1'b0, k)) begin n_fail++; $display("FAIL rstmid_next_tdata k=%0d got %h exp %h", k, axi_tx_tdata, exp_beat(g, 1'b0, 1'b0, k)); end
      n_checks++; if (axi_tx_tlast !== (k == nb-1)) begin n_fail++; $display("FAIL rstmid_next_tlast k=%0d got %b exp %b", k, axi_tx_tlast, (k == nb-1)); end
    end
    @(negedge sys_clk);
    n_checks++; if (o_frame_sent !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_sent got %b exp 1", o_frame_sent); end
    @(negedge sys_clk);
  endtask

`ifdef ENDEC_AXIS_TX_HDR_EN
  task automatic test_header;
    logic [383:0] f;
    logic [31:0]  w;
    f = make_frame(32'h0000_0011);
    i_frame_data = f; i_code_rate = 1'b1; i_constr_len = 1'b1;
    i_frame_valid = 1'b1; axi_tx_tready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge sys_clk);
      i_frame_valid = 1'b0;
      w = (k == 0) ? 32'hA000_0C03 : f[(k-1)*32 +: 32];
      n_checks++; if (axi_tx_tdata !== w) begin n_fail++; $display("FAIL hdr_tdata k=%0d got %h exp %h", k, axi_tx_tdata, w); end
      n_checks++; if (axi_tx_tlast !== (k == 12)) begin n_fail++; $display("FAIL hdr_tlast k=%0d got %b exp %b", k, axi_tx_tlast, (k == 12)); end
    end
    @(negedge sys_clk);
    n_checks++; if (o_frame_sent !== 1'b1) begin n_fail++; $display("FAIL hdr_sent got %b exp 1", o_frame_sent); end
    @(negedge sys_clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rate_half();
    test_rate_third_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef ENDEC_AXIS_TX_HDR_EN
    test_header();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
